// File: rtl/algo_nrmw_chk_pkg.sv
// Shared definitions for the multi-port memory read/write checker: error bit
// positions and the per-port read pipeline stage record.
package algo_nrmw_chk_pkg;

  localparam int CHK_MAXW = 64;

  // Per-read-port hit vector positions
  localparam int ERR_DATA  = 0;
  localparam int ERR_VLD   = 1;
  localparam int ERR_NPORT = 2;

  // Block-wide hit vector positions
  localparam int ERR_COLL = 0;
  localparam int ERR_ADR  = 1;
  localparam int ERR_NGLB = 2;

  // skip masks the data compare (unwritten location), like rd_derr does
  typedef struct packed {
    logic                vld;
    logic [CHK_MAXW-1:0] data;
    logic                skip;
  } rdStage_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/algo_chk_rdpipe.sv
// One read port of the checker: carries the expected {valid, data, skip} for
// DELAY cycles and compares it with what the memory under test returned.
module algo_chk_rdpipe
  import algo_nrmw_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inVld,
  input  logic                 inSkip,
  input  logic [WIDTH-1:0]     inData,
  input  logic [WIDTH-1:0]     rdDout,
  input  logic                 rdVld,
  input  logic                 rdDerr,
  output logic [ERR_NPORT-1:0] hit
);

  rdStage_t stage_p0;
  rdStage_t pipe [DELAY];
  rdStage_t cmp;

  always_comb begin
    stage_p0      = '0;
    stage_p0.vld  = inVld;
    stage_p0.data = CHK_MAXW'(inData);
    stage_p0.skip = inSkip;
  end

  // stage p0 -> p1..pDELAY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DELAY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= stage_p0;
      for (int k = 1; k < DELAY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign cmp = pipe[DELAY-1];

  // compare stage: result is registered by the parent
  always_comb begin
    hit           = '0;
    hit[ERR_VLD]  = cmp.vld ^ rdVld;
    hit[ERR_DATA] = cmp.vld & rdVld & ~rdDerr & ~cmp.skip &
                    (cmp.data != CHK_MAXW'(rdDout));
  end

endmodule

// File: rtl/algo_nrmw_chk.sv
// Scoreboard checker for an NUMRDPT-read / NUMWRPT-write memory with fixed read
// latency. Define ALGO_CHK_INIT_EN to track written locations and skip data
// compares on never-written addresses.
module algo_nrmw_chk
  import algo_nrmw_chk_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUMADDR = 256,
  parameter int BITADDR = 8,
  parameter int NUMRDPT = 2,
  parameter int NUMWRPT = 2,
  parameter int DELAY   = 2,
  parameter int CNTW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT-1:0]         rd_derr,
  output logic [NUMRDPT-1:0]         err_data,
  output logic [NUMRDPT-1:0]         err_vld,
  output logic                       err_coll,
  output logic                       err_adr,
  output logic [CNTW-1:0]            err_cnt
);

  localparam int IDXW = idxWidth(NUMADDR);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  function automatic logic inRange(input logic [BITADDR-1:0] adr);
    return 64'(adr) < 64'(NUMADDR);
  endfunction

  function automatic logic [CNTW-1:0] satAdd(input logic [CNTW-1:0] cnt,
                                             input logic [7:0] inc);
    logic [CNTW+8:0] sum;
    sum = (CNTW+9)'(cnt) + (CNTW+9)'(inc);
    return (sum > (CNTW+9)'(CNT_MAX)) ? CNT_MAX : sum[CNTW-1:0];
  endfunction

  logic [BITADDR-1:0]   wrAdrA [NUMWRPT];
  logic [WIDTH-1:0]     dinA   [NUMWRPT];
  logic [NUMWRPT-1:0]   wrAcc, wrOk;
  logic [BITADDR-1:0]   rdAdrA [NUMRDPT];
  logic [NUMRDPT-1:0]   rdAcc, rdOk, skipA;
  logic [ERR_NPORT-1:0] hitA   [NUMRDPT];
  logic [ERR_NGLB-1:0]  glbNxt;
  logic [NUMRDPT-1:0]   dataNxt, vldNxt;
  logic [7:0]           errSum;
  logic [WIDTH-1:0]     shadow [NUMADDR];

  for (genvar i = 0; i < NUMWRPT; i++) begin : gWr
    assign wrAdrA[i] = wr_adr[i*BITADDR +: BITADDR];
    assign dinA[i]   = din[i*WIDTH +: WIDTH];
    assign wrAcc[i]  = ready & write[i];
    assign wrOk[i]   = wrAcc[i] & inRange(wrAdrA[i]);
  end

  // Later ports are applied last so the highest index wins on a collision
`ifdef ALGO_CHK_INIT_EN
  logic [NUMADDR-1:0] written;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
    end else begin
      for (int i = 0; i < NUMWRPT; i++)
        if (wrOk[i]) written[wrAdrA[i][IDXW-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMWRPT; i++)
      if (wrOk[i]) shadow[wrAdrA[i][IDXW-1:0]] <= dinA[i];
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NUMADDR; a++) shadow[a] <= '0;
    end else begin
      for (int i = 0; i < NUMWRPT; i++)
        if (wrOk[i]) shadow[wrAdrA[i][IDXW-1:0]] <= dinA[i];
    end
  end
`endif

  // Expected data is sampled before this cycle's writes land (read-before-write)
  for (genvar g = 0; g < NUMRDPT; g++) begin : gRd
    assign rdAdrA[g] = rd_adr[g*BITADDR +: BITADDR];
    assign rdAcc[g]  = ready & read[g];
    assign rdOk[g]   = rdAcc[g] & inRange(rdAdrA[g]);
`ifdef ALGO_CHK_INIT_EN
    assign skipA[g]  = ~written[rdAdrA[g][IDXW-1:0]];
`else
    assign skipA[g]  = 1'b0;
`endif

    algo_chk_rdpipe #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
    ) uRdPipe (
      .clk    (clk),
      .rst    (rst),
      .inVld  (rdOk[g]),
      .inSkip (skipA[g]),
      .inData (shadow[rdAdrA[g][IDXW-1:0]]),
      .rdDout (rd_dout[g*WIDTH +: WIDTH]),
      .rdVld  (rd_vld[g]),
      .rdDerr (rd_derr[g]),
      .hit    (hitA[g])
    );
  end

  always_comb begin
    glbNxt = '0;
    for (int i = 0; i < NUMWRPT; i++)
      if (wrAcc[i] && !wrOk[i]) glbNxt[ERR_ADR] = 1'b1;
    for (int g = 0; g < NUMRDPT; g++)
      if (rdAcc[g] && !rdOk[g]) glbNxt[ERR_ADR] = 1'b1;
    for (int i = 0; i < NUMWRPT; i++)
      for (int j = i + 1; j < NUMWRPT; j++)
        if (wrOk[i] && wrOk[j] && (wrAdrA[i] == wrAdrA[j])) glbNxt[ERR_COLL] = 1'b1;
  end

  always_comb begin
    dataNxt = '0;
    vldNxt  = '0;
    errSum  = 8'(glbNxt[ERR_COLL]) + 8'(glbNxt[ERR_ADR]);
    for (int g = 0; g < NUMRDPT; g++) begin
      dataNxt[g] = hitA[g][ERR_DATA];
      vldNxt[g]  = hitA[g][ERR_VLD];
      errSum     = errSum + 8'(dataNxt[g]) + 8'(vldNxt[g]);
    end
  end

  // error register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_data <= '0;
      err_vld  <= '0;
      err_coll <= 1'b0;
      err_adr  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err_data <= dataNxt;
      err_vld  <= vldNxt;
      err_coll <= glbNxt[ERR_COLL];
      err_adr  <= glbNxt[ERR_ADR];
      err_cnt  <= satAdd(err_cnt, errSum);
    end
  end

endmodule

// File: tb/tb_algo_nrmw_chk.sv
// Directed bench for algo_nrmw_chk: a 16-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream.
module tb_algo_nrmw_chk;

  localparam int W  = 32;
  localparam int NA = 256;
  localparam int BA = 9;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [NW-1:0]   write;
  logic [NW*BA-1:0] wr_adr;
  logic [NW*W-1:0] din;
  logic [NR-1:0]   read;
  logic [NR*BA-1:0] rd_adr;
  logic [NR*W-1:0] rd_dout;
  logic [NR-1:0]   rd_vld, rd_derr;
  logic [NR-1:0]   errData, errVld, sData, sVld;
  logic            errColl, errAdr, sColl, sAdr;
  logic [15:0]     errCnt;
  logic [3:0]      sCnt;

  int nChk = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  algo_nrmw_chk #(.WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMRDPT(NR),
                  .NUMWRPT(NW), .DELAY(DL), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .ready(ready), .write(write), .wr_adr(wr_adr),
    .din(din), .read(read), .rd_adr(rd_adr), .rd_dout(rd_dout),
    .rd_vld(rd_vld), .rd_derr(rd_derr), .err_data(errData), .err_vld(errVld),
    .err_coll(errColl), .err_adr(errAdr), .err_cnt(errCnt));

  algo_nrmw_chk #(.WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .NUMRDPT(NR),
                  .NUMWRPT(NW), .DELAY(DL), .CNTW(4)) dutSmall (
    .clk(clk), .rst(rst), .ready(ready), .write(write), .wr_adr(wr_adr),
    .din(din), .read(read), .rd_adr(rd_adr), .rd_dout(rd_dout),
    .rd_vld(rd_vld), .rd_derr(rd_derr), .err_data(sData), .err_vld(sVld),
    .err_coll(sColl), .err_adr(sAdr), .err_cnt(sCnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    write = '0; wr_adr = '0; din = '0;
    read = '0; rd_adr = '0;
    rd_vld = '0; rd_derr = '0; rd_dout = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input int p, input int a, input logic [W-1:0] d);
    write[p] = 1'b1;
    wr_adr[p*BA +: BA] = BA'(a);
    din[p*W +: W] = d;
  endtask

  task automatic rd(input int p, input int a);
    read[p] = 1'b1;
    rd_adr[p*BA +: BA] = BA'(a);
  endtask

  task automatic resp(input int p, input logic [W-1:0] d);
    rd_vld[p] = 1'b1;
    rd_dout[p*W +: W] = d;
  endtask

  initial begin
    logic [W-1:0] unwrVal;
    rst = 1'b0;
    ready = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", errCnt, 0);
    chk("rst_vld", errVld, 0);
    chk("rst_data", errData, 0);
    chk("rst_coll", errColl, 0);
    chk("rst_adr", errAdr, 0);
    rst = 1'b1;
    cyc();

    // matching read
    wr(0, 5, 32'hDEADBEEF); cyc(); cyc();
    rd(0, 5); cyc(); cyc();
    resp(0, 32'hDEADBEEF); cyc();
    chk("s1_data", errData, 0);
    chk("s1_vld", errVld, 0);
    chk("s1_cnt", errCnt, 0);

    // corrupted read data
    rd(0, 5); cyc(); cyc();
    resp(0, 32'hDEADBEEE); cyc();
    chk("s2_data", errData, 2'b01);
    chk("s2_cnt", errCnt, 1);
    cyc();
    chk("s2_pulse", errData, 0);

    // missing valid, then spurious valid
    rd(0, 5); cyc(); cyc(); cyc();
    chk("s3_miss", errVld, 2'b01);
    chk("s3_miss_cnt", errCnt, 2);
    resp(1, 32'h0); cyc();
    chk("s3_spur", errVld, 2'b10);
    chk("s3_spur_cnt", errCnt, 3);

    // write collision: port 1 wins
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); cyc();
    chk("s4_coll", errColl, 1);
    chk("s4_coll_cnt", errCnt, 4);
    rd(0, 7); rd(1, 7); cyc();
    chk("s4_coll_pulse", errColl, 0);
    cyc();
    resp(0, 32'h22); resp(1, 32'h22); cyc();
    chk("s4_data", errData, 0);
    chk("s4_cnt", errCnt, 4);

    // out-of-range write leaves shadow untouched
    wr(0, 44, 32'h1234); cyc();
    wr(1, 300, 32'h9999); cyc();
    chk("s5_adr", errAdr, 1);
    chk("s5_coll", errColl, 0);
    chk("s5_cnt", errCnt, 5);
    rd(0, 44); cyc(); cyc();
    resp(0, 32'h1234); cyc();
    chk("s5_shadow", errData, 0);

    // read-before-write, and a write during the compare cycle
    rd(0, 5); wr(0, 5, 32'hCAFEF00D); cyc(); cyc();
    resp(0, 32'hDEADBEEF); wr(1, 5, 32'h0BADF00D); cyc();
    chk("rbw_data", errData, 0);
    rd(0, 5); cyc(); cyc();
    resp(0, 32'h0BADF00D); cyc();
    chk("rbw_new", errData, 0);
    chk("rbw_cnt", errCnt, 5);

    // stimulus ignored while not ready
    ready = 1'b0; wr(0, 5, 32'hFFFFFFFF); rd(0, 5); cyc();
    ready = 1'b1; cyc(); cyc();
    chk("rdy_vld", errVld, 0);
    rd(0, 5); cyc(); cyc();
    resp(0, 32'h0BADF00D); cyc();
    chk("rdy_data", errData, 0);

    // uncorrectable flag suppresses the data compare
    rd(0, 5); cyc(); cyc();
    resp(0, 32'h0); rd_derr[0] = 1'b1; cyc();
    chk("derr_data", errData, 0);
    chk("derr_vld", errVld, 0);
    chk("derr_cnt", errCnt, 5);
    chk("small_cnt5", sCnt, 5);

    // reset with two reads in flight
    rd(0, 5); rd(1, 7); cyc(); cyc();
    rst = 1'b0;
    #2;
    chk("async_cnt", errCnt, 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("flush_vld", errVld, 0);
    end
    chk("flush_cnt", errCnt, 0);

    // read of a never-written address
`ifdef ALGO_CHK_INIT_EN
    unwrVal = 32'h5A;
`else
    unwrVal = 32'h0;
`endif
    rd(0, 9); cyc(); cyc();
    resp(0, unwrVal); cyc();
    chk("unwr_data", errData, 0);
    chk("unwr_cnt", errCnt, 0);

    // saturation: 20 errors
    for (int i = 0; i < 10; i++) begin
      resp(0, 32'h0); resp(1, 32'h0); cyc();
      chk("sat_vld", errVld, 2'b11);
    end
    chk("sat_big", errCnt, 20);
    chk("sat_small", sCnt, 15);
    resp(0, 32'h0); cyc();
    chk("sat_hold", sCnt, 15);
    chk("sat_big21", errCnt, 21);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
